// File: rtl/uwire_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uwire_pkg
// Description : Shared types and constants for the MICROWIRE (uWire) link
//               that configures the LMK04816 clock cleaner. Imported by the
//               uWire slave, its interface, the LMK master and the loader.
// Contents    : UWIRE_WORD_BITS / UWIRE_ADDR_BITS / UWIRE_NUM_REGS,
//               receive FSM state enum, bit-counter width and saturation
//               value, address extraction helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uwire_pkg;

  localparam int UWIRE_WORD_BITS = 32;
  localparam int UWIRE_ADDR_BITS = 5;
  localparam int UWIRE_NUM_REGS  = 32;

  // Bit counter is wide enough to count one past a full word, so any
  // over-length frame parks at 33 and can never alias back to 32.
  localparam int                        UWIRE_CNT_BITS = 6;
  localparam logic [UWIRE_CNT_BITS-1:0] UWIRE_CNT_FULL = 6'd32;
  localparam logic [UWIRE_CNT_BITS-1:0] UWIRE_CNT_SAT  = 6'd33;

  typedef logic [UWIRE_WORD_BITS-1:0] uwire_word_t;
  typedef logic [UWIRE_ADDR_BITS-1:0] uwire_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } uwire_rx_state_t;

  // LMK register address lives in the five LSBs of every word.
  function automatic uwire_addr_t uwire_addr_of(input uwire_word_t w);
    return w[UWIRE_ADDR_BITS-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uwire_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : uwire_slave_if
// Description : Bundle of the uWire pins, the decoded-frame outputs and the
//               shadow read port of the uWire slave.
// Modports    : master - drives uwire_clk/uwire_data/uwire_le and rd_addr,
//                        observes word_q, addr_q, word_valid, frame_err,
//                        frame_count, rd_data
//               slave  - the opposite directions
// Parameters  : FRAME_CNT_BITS - width of frame_count
// Revision    : 1.0 - initial release
// ============================================================================
interface uwire_slave_if
  import uwire_pkg::*;
#(
  parameter int FRAME_CNT_BITS = 16
) ();

  logic                      uwire_clk;
  logic                      uwire_data;
  logic                      uwire_le;
  uwire_word_t               word_q;
  uwire_addr_t               addr_q;
  logic                      word_valid;
  logic                      frame_err;
  logic [FRAME_CNT_BITS-1:0] frame_count;
  uwire_addr_t               rd_addr;
  uwire_word_t               rd_data;

  modport master (
    output uwire_clk, uwire_data, uwire_le, rd_addr,
    input  word_q, addr_q, word_valid, frame_err, frame_count, rd_data
  );

  modport slave (
    input  uwire_clk, uwire_data, uwire_le, rd_addr,
    output word_q, addr_q, word_valid, frame_err, frame_count, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/uwire_slave_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : uwire_sync_edge
// Description : Multi-flop synchronizer for one asynchronous uWire pin,
//               followed by a delay flop. Level, rise and fall are decoded
//               from the last synchronizer flop and the delay flop.
// Ports       : clk      in  sampling clock
//               rst      in  asynchronous active-low reset
//               async_i  in  asynchronous pin
//               level_o  out synchronized level
//               rise_o   out one-cycle pulse on a 0->1 transition
//               fall_o   out one-cycle pulse on a 1->0 transition
// Parameters  : SYNC_STAGES - synchronizer depth (>= 2)
//               RESET_VAL   - value loaded into every flop during reset
// Revision    : 1.0 - initial release
// ============================================================================
module uwire_sync_edge #(
  parameter int   SYNC_STAGES = 3,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  // Marks which flops already hold a post-reset sample. Edges are qualified
  // only once the delay flop does, so a pin that differs from RESET_VAL at
  // reset release settles silently instead of looking like a real edge.
  logic [SYNC_STAGES:0]   primed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      delay_q  <= RESET_VAL;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
      delay_q  <= sync_q[SYNC_STAGES-1];
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = primed_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~delay_q;
  assign fall_o  = primed_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  delay_q;

endmodule
`default_nettype wire

// File: rtl/uwire_slave.sv
`default_nettype none
// ============================================================================
// Module      : uwire_slave
// Description : MICROWIRE receiver for the LMK04816 configuration bus.
//               Oversamples CLK/DATA/LE, shifts 32-bit MSB-first frames and
//               on each LE rise either accepts the frame (exactly 32 bits)
//               or flags a framing error. Accepted words optionally update
//               a 32-entry shadow register file.
// Ports       : clk  in  sampling clock (>= 4x uWire clock)
//               rst  in  asynchronous active-low reset
//               bus  slave modport of uwire_slave_if:
//                    uwire_clk/uwire_data/uwire_le in  uWire pins
//                    word_q      out last accepted 32-bit frame
//                    addr_q      out word_q[4:0]
//                    word_valid  out pulse when word_q/addr_q update
//                    frame_err   out pulse on LE rise with count != 32
//                    frame_count out accepted-frame count (wraps)
//                    rd_addr     in  shadow read address
//                    rd_data     out shadow contents, 1-cycle latency
// Parameters  : SYNC_STAGES    - synchronizer depth per pin (>= 2)
//               FRAME_CNT_BITS - frame_count width (match the interface)
// Macros      : UWIRE_SLAVE_SHADOW_EN - build the shadow register file and
//               its read port; otherwise rd_data is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uwire_slave
  import uwire_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic          clk,
  input  logic          rst,
  uwire_slave_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Pin synchronizers. LE idles high, so its chain resets high.
  // --------------------------------------------------------------------------
  logic clk_level, clk_rise, clk_fall;
  logic data_level, data_rise, data_fall;
  logic le_level, le_rise, le_fall;

  uwire_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.uwire_clk),
    .level_o (clk_level),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall)
  );

  uwire_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.uwire_data),
    .level_o (data_level),
    .rise_o  (data_rise),
    .fall_o  (data_fall)
  );

  uwire_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_le (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.uwire_le),
    .level_o (le_level),
    .rise_o  (le_rise),
    .fall_o  (le_fall)
  );

  // --------------------------------------------------------------------------
  // Receive state
  // --------------------------------------------------------------------------
  uwire_rx_state_t           state_q;
  uwire_word_t               shreg_q, shreg_d;
  logic [UWIRE_CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  uwire_word_t               out_word_q;
  uwire_addr_t               out_addr_q;
  logic                      word_valid_q;
  logic                      frame_err_q;
  logic [FRAME_CNT_BITS-1:0] frame_count_q, frame_count_d;
  logic                      frame_ok;

  always_comb begin
    shreg_d       = {shreg_q[UWIRE_WORD_BITS-2:0], data_level};
    bit_cnt_d     = (bit_cnt_q == UWIRE_CNT_SAT) ? bit_cnt_q
                                                 : bit_cnt_q + 6'd1;
    frame_count_d = frame_count_q + {{(FRAME_CNT_BITS-1){1'b0}}, 1'b1};
    frame_ok      = (bit_cnt_q == UWIRE_CNT_FULL);
  end

  // In SHIFT the shift is applied before the LE-rise transition is taken, so
  // a CLK rise coincident with the LE rise still contributes its bit: LATCH
  // then evaluates the already-updated bit_cnt_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      out_word_q    <= '0;
      out_addr_q    <= '0;
      word_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (le_fall) begin
            state_q   <= SHIFT;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
          end
          if (le_rise) begin
            state_q <= LATCH;
          end
        end
        LATCH: begin
          state_q <= IDLE;
          if (frame_ok) begin
            out_word_q    <= shreg_q;
            out_addr_q    <= uwire_addr_of(shreg_q);
            word_valid_q  <= 1'b1;
            frame_count_q <= frame_count_d;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.word_q      = out_word_q;
  assign bus.addr_q      = out_addr_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_count = frame_count_q;

  // --------------------------------------------------------------------------
  // Shadow register file
  // --------------------------------------------------------------------------
`ifdef UWIRE_SLAVE_SHADOW_EN
  uwire_word_t shadow_q [UWIRE_NUM_REGS];
  uwire_word_t rd_data_q;
  logic        shadow_we;

  assign shadow_we = (state_q == LATCH) && frame_ok;

  // Read samples the array before this edge's write lands, so a same-cycle
  // read of the written entry returns the previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < UWIRE_NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      rd_data_q <= shadow_q[bus.rd_addr];
      if (shadow_we) begin
        shadow_q[uwire_addr_of(shreg_q)] <= shreg_q;
      end
    end
  end

  assign bus.rd_data = rd_data_q;

  logic unused_sig;
  assign unused_sig = ^{clk_level, clk_fall, data_rise, data_fall, le_level};
`else
  assign bus.rd_data = '0;

  logic unused_sig;
  assign unused_sig = ^{clk_level, clk_fall, data_rise, data_fall, le_level,
                        bus.rd_addr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_uwire_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_uwire_slave
// Description : Self-checking bench for uwire_slave. Drives uWire frames at
//               clk/8, compares decoded outputs, pulse counts and shadow
//               reads against hand-computed tables and a small model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uwire_slave;

  localparam int FCB = 5;  // narrow counter so the wrap is reachable

`ifdef UWIRE_SLAVE_SHADOW_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uwire_slave_if #(.FRAME_CNT_BITS(FCB)) bus ();

  uwire_slave #(.SYNC_STAGES(3), .FRAME_CNT_BITS(FCB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;

  // model of the architectural state
  logic [31:0]    model_word;
  logic [4:0]     model_addr;
  logic [FCB-1:0] model_count;
  logic [31:0]    shadow_m [32];

  typedef struct {
    logic [31:0] word;
    int          nbits;
    logic        exp_valid;
    logic [4:0]  exp_addr;
  } vec_t;
  vec_t vecs [26];

  always @(negedge clk) begin
    if (bus.word_valid) wv_cnt++;
    if (bus.frame_err)  fe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    model_word  = '0;
    model_addr  = '0;
    model_count = '0;
    for (int i = 0; i < 32; i++) shadow_m[i] = '0;
  endtask

  task automatic rd_chk(input string name, input int a);
    logic [31:0] exp;
    bus.rd_addr = 5'(a);
    tick(1);
    exp = SHADOW_EN ? shadow_m[a] : 32'h0;
    chk(name, bus.rd_data, exp);
  endtask

  task automatic shift_bit(input logic b);
    bus.uwire_data = b;
    bus.uwire_clk  = 1'b0;
    tick(4);
    bus.uwire_clk  = 1'b1;
    tick(4);
  endtask

  task automatic run_frame(input string name, input logic [31:0] w, input int n,
                           input bit joint, input logic exp_valid, input logic [4:0] exp_addr);
    int   wv0, fe0;
    logic b;
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    bus.uwire_clk = 1'b0;
    bus.uwire_le  = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      b = (i < 32) ? w[31 - i] : 1'b0;
      if (joint && (i == n - 1)) begin
        bus.uwire_data = b;
        bus.uwire_clk  = 1'b0;
        tick(4);
        bus.uwire_clk  = 1'b1;
        bus.uwire_le   = 1'b1;
        tick(4);
        chk({name, "_lat4"}, 32'(bus.word_valid), 32'd0);
        tick(1);
        chk({name, "_lat5"}, 32'(bus.word_valid), 32'(exp_valid));
        tick(1);
        chk({name, "_lat6"}, 32'(bus.word_valid), 32'd0);
      end else begin
        shift_bit(b);
      end
    end
    if (!joint) begin
      bus.uwire_clk = 1'b0;
      tick(4);
      bus.uwire_le = 1'b1;
    end
    tick(12);
    bus.uwire_clk = 1'b0;
    if (exp_valid) begin
      model_word           = w;
      model_addr           = exp_addr;
      model_count          = model_count + 1'b1;
      shadow_m[exp_addr]   = w;
    end
    chk({name, "_wv"},    32'(wv_cnt - wv0), 32'(exp_valid));
    chk({name, "_fe"},    32'(fe_cnt - fe0), 32'(!exp_valid));
    chk({name, "_word"},  bus.word_q, model_word);
    chk({name, "_addr"},  32'(bus.addr_q), 32'(model_addr));
    chk({name, "_count"}, 32'(bus.frame_count), 32'(model_count));
  endtask

  initial begin
    vecs[0]  = '{32'h80160140, 32, 1'b1, 5'd0};
    vecs[1]  = '{32'h00140040, 32, 1'b1, 5'd0};
    vecs[2]  = '{32'h00140041, 32, 1'b1, 5'd1};
    vecs[3]  = '{32'h00140042, 32, 1'b1, 5'd2};
    vecs[4]  = '{32'h00140043, 32, 1'b1, 5'd3};
    vecs[5]  = '{32'h00140044, 32, 1'b1, 5'd4};
    vecs[6]  = '{32'h00140045, 32, 1'b1, 5'd5};
    vecs[7]  = '{32'h55555546, 32, 1'b1, 5'd6};
    vecs[8]  = '{32'h11110007, 32, 1'b1, 5'd7};
    vecs[9]  = '{32'h55555548, 32, 1'b1, 5'd8};
    vecs[10] = '{32'h55555549, 32, 1'b1, 5'd9};
    vecs[11] = '{32'h914249AA, 32, 1'b1, 5'd10};
    vecs[12] = '{32'h0401100B, 32, 1'b1, 5'd11};
    vecs[13] = '{32'h1B0C006C, 32, 1'b1, 5'd12};
    vecs[14] = '{32'h2302806D, 32, 1'b1, 5'd13};
    vecs[15] = '{32'h0200000E, 32, 1'b1, 5'd14};
    vecs[16] = '{32'h8000800F, 32, 1'b1, 5'd15};
    vecs[17] = '{32'hC1550410, 32, 1'b1, 5'd16};
    vecs[18] = '{32'h00000058, 32, 1'b1, 5'd24};
    vecs[19] = '{32'h02C9C419, 32, 1'b1, 5'd25};
    vecs[20] = '{32'h8FA8001A, 32, 1'b1, 5'd26};
    vecs[21] = '{32'h10001F5B, 32, 1'b1, 5'd27};
    vecs[22] = '{32'h0001801C, 32, 1'b1, 5'd28};
    vecs[23] = '{32'h0080001D, 32, 1'b1, 5'd29};
    vecs[24] = '{32'h0200033E, 32, 1'b1, 5'd30};
    vecs[25] = '{32'h001F001F, 32, 1'b1, 5'd31};

    bus.uwire_clk  = 1'b0;
    bus.uwire_data = 1'b0;
    bus.uwire_le   = 1'b1;
    bus.rd_addr    = 5'd0;
    model_clear();

    // ---- reset state
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(10);
    chk("rst_word",  bus.word_q, 32'h0);
    chk("rst_addr",  32'(bus.addr_q), 32'h0);
    chk("rst_wv",    32'(bus.word_valid), 32'h0);
    chk("rst_fe",    32'(bus.frame_err), 32'h0);
    chk("rst_count", 32'(bus.frame_count), 32'h0);
    chk("rst_pulses", 32'(wv_cnt + fe_cnt), 32'h0);
    rd_chk("rst_rd0", 0);

    // ---- basic accepted frame and shadow read-back
    run_frame("f80160140", 32'h80160140, 32, 1'b0, 1'b1, 5'd0);
    rd_chk("f80160140_rd0", 0);

    // ---- framing errors: too short and too long
    run_frame("short31", 32'hA5A5A5A5, 31, 1'b0, 1'b0, 5'd0);
    rd_chk("short31_rd18", 18);
    rd_chk("short31_rd0", 0);
    run_frame("long40", 32'h12345678, 40, 1'b0, 1'b0, 5'd0);
    rd_chk("long40_rd24", 24);

    // ---- reset in the middle of a frame
    begin
      int wv0, fe0;
      bus.uwire_le = 1'b0;
      tick(4);
      for (int i = 0; i < 16; i++) shift_bit(i[0]);
      bus.uwire_clk = 1'b0;
      rst = 1'b0;
      tick(2);
      model_clear();
      chk("mid_rst_word",  bus.word_q, 32'h0);
      chk("mid_rst_count", 32'(bus.frame_count), 32'h0);
      rst = 1'b1;
      tick(10);
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      bus.uwire_le = 1'b1;
      tick(15);
      chk("mid_rst_wv",   32'(wv_cnt - wv0), 32'h0);
      chk("mid_rst_fe",   32'(fe_cnt - fe0), 32'h0);
      chk("mid_rst_addr", 32'(bus.addr_q), 32'h0);
      chk("mid_rst_word2", bus.word_q, 32'h0);
      rd_chk("mid_rst_rd0", 0);
    end
    run_frame("f0B8C01AC", 32'h0B8C01AC, 32, 1'b0, 1'b1, 5'd12);
    chk("f0B8C01AC_addr12", 32'(bus.addr_q), 32'd12);

    // ---- last CLK rise coincident with LE rise
    run_frame("joint", 32'h130086ED, 32, 1'b1, 1'b1, 5'd13);
    chk("joint_addr13", 32'(bus.addr_q), 32'd13);
    rd_chk("joint_rd13", 13);

    // ---- full LMK04816 configuration from a clean reset
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    model_clear();
    tick(10);
    for (int i = 0; i < 26; i++) begin
      run_frame($sformatf("lmk%0d", i), vecs[i].word, vecs[i].nbits, 1'b0,
                vecs[i].exp_valid, vecs[i].exp_addr);
    end
    chk("lmk_count26", 32'(bus.frame_count), 32'd26);
    rd_chk("lmk_rd10", 10);
    rd_chk("lmk_rd31", 31);
    for (int a = 0; a < 32; a++) rd_chk($sformatf("lmk_rd_all%0d", a), a);

    // ---- frame counter wraps to zero
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("wrap%0d", i), vecs[i].word, 32, 1'b0, 1'b1, vecs[i].exp_addr);
    end
    chk("wrap_zero", 32'(bus.frame_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uwire_slave.md
# uwire_slave

Receiving end of the MICROWIRE (uWire) link that configures the LMK04816 clock cleaner. The block oversamples the CLK/DATA/LE lines in the local clock domain and shifts in 32-bit MSB-first frames. On each LE rising edge it decodes the 5-bit register address and, optionally, writes the word into a 32-entry shadow register file. It sits beside the clock subsystem as a loopback and verification tap on the LMK configuration bus, and as an in-fabric uWire target for bench and board self-test.

## Interface
- SYNC_STAGES, 3, synchronizer depth on each uWire input (≥2)
- FRAME_CNT_BITS, 16, width of the accepted-frame counter
- clk  in  1  sampling clock; must be ≥4× the uWire clock rate
- rst  in  1  asynchronous, active-low reset
- uwire_clk  in  1  uWire CLK pin, asynchronous to clk
- uwire_data  in  1  uWire DATA pin, sampled on uwire_clk rising edges
- uwire_le  in  1  uWire LE pin; low while shifting, rising edge latches the frame
- word_q  out  32  last accepted frame, full 32 bits including the address field
- addr_q  out  5  word_q[4:0] of the last accepted frame
- word_valid  out  1  one-cycle pulse when word_q/addr_q update
- frame_err  out  1  one-cycle pulse on LE rise with bit count ≠ 32
- frame_count  out  FRAME_CNT_BITS  number of accepted frames; wraps to 0
- rd_addr  in  5  shadow read address
- rd_data  out  32  shadow register contents at rd_addr

## Operation
- Each input passes through SYNC_STAGES flops and one delay flop. Rise and fall are decoded from the last two flops.
- Synchronizer reset values: clk and data paths 0; LE path 1, so that reset cannot produce a false LE fall.
- FSM states:
  - IDLE: after reset. Moves to SHIFT on an LE falling edge, which clears shreg and bit_cnt. LE rises and CLK rises in IDLE are ignored.
  - SHIFT: each CLK rise does shreg <= {shreg[30:0], data_sync} and increments bit_cnt. bit_cnt is 6 bits and saturates at 33. An LE rise moves to LATCH.
  - LATCH: one cycle, then IDLE.
- Frame check in LATCH:
  - If bit_cnt == 32: word_q <= shreg, addr_q <= shreg[4:0], pulse word_valid, increment frame_count, and write shadow[shreg[4:0]] <= shreg.
  - Otherwise: pulse frame_err only. word_q, addr_q, frame_count and the shadow file are unchanged.
- A CLK rise and an LE rise detected in the same cycle: the bit is shifted first, and the frame check uses the updated bit_cnt.
- Reset mid-frame clears all state. A partial frame still in progress at reset release is discarded silently: no error, because IDLE ignores the LE rise.
- frame_count wraps from all-ones to 0.
- uwire_data is used only at CLK rises; it has no other effect.

## Timing
- Reset values: word_q 0, addr_q 0, word_valid 0, frame_err 0, frame_count 0, all shadow entries 0, rd_data 0.
- An LE rise is seen internally SYNC_STAGES+1 clk edges after the first clk edge that samples the pin high.
- word_valid and frame_err assert SYNC_STAGES+2 cycles after that first sampling edge (5 cycles at the default).
- word_q, addr_q and frame_count change in the same cycle word_valid is high.
- rd_data is registered, with one-cycle latency from rd_addr.
- A read and a write to the same address in the same cycle return the old value (read-before-write).
- Minimum uWire CLK high time and low time: 2 clk periods. Minimum LE low-to-first-CLK setup: 2 clk periods.

## Configuration
- UWIRE_SLAVE_SHADOW_EN defined: the 32×32 shadow register file and the registered read port are built.
- UWIRE_SLAVE_SHADOW_EN undefined: no storage is built, and rd_data is held at 0. rd_addr is ignored. All other behaviour is identical.

## Structure
- Package uwire_pkg holds:
  - UWIRE_WORD_BITS = 32
  - UWIRE_ADDR_BITS = 5
  - UWIRE_NUM_REGS = 32
  - enum uwire_rx_state_t {IDLE, SHIFT, LATCH}
- The LMK master and loader also import uwire_pkg.
- One sub-module, uwire_sync_edge: a SYNC_STAGES synchronizer plus delay flop with a reset-value parameter, producing level, rise and fall outputs. It is instantiated three times.

## Test plan
- Frame 32'h80160140 at uWire CLK = clk/8 -> one word_valid pulse, word_q = 32'h80160140, addr_q = 0, frame_count = 1; rd_addr = 0 gives rd_data = 32'h80160140 one cycle later.
- 31 bits then LE rise -> frame_err pulses exactly once; word_valid stays 0; frame_count and shadow are unchanged. Repeat with 40 bits -> same result.
- Full 26-word LMK04816 configuration sequence -> frame_count = 26, no frame_err; shadow[10] = 32'h914249AA, shadow[31] = 32'h001F001F.
- Assert rst after 16 bits of a frame, release while LE is low, then raise LE -> all outputs 0, no pulse; the next complete frame 32'h0B8C01AC gives addr_q = 12.
- Last CLK rise and LE rise in the same clk cycle on a 32-bit frame -> accepted with the final bit included; word_valid 5 cycles after the LE edge.
- Build without UWIRE_SLAVE_SHADOW_EN, send 32'h130086ED -> word_valid and addr_q = 13 as normal; rd_data stays 0 for every rd_addr.
